fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/datapath parameters: opcode encoding and fetch FSM state type.
package fetch_unit_pkg;

  localparam int OPCODE_WIDTH = 4;

  localparam logic [OPCODE_WIDTH-1:0] OPC_HALT = '1;
  localparam logic [OPCODE_WIDTH-1:0] OPC_NOP  = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Fetch sequencer: issues one instruction per two clocks from a synchronous imem,
// drains the datapath after HALT or the last address, and pulses done on completion.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int INS_ADDR_WIDTH = 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int INS_WIDTH      = OPCODE_WIDTH + 3 * ADDR_WIDTH,
  parameter int PIPE_DEPTH     = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      abort,
  output logic [INS_ADDR_WIDTH-1:0] imem_addr,
  input  logic [INS_WIDTH-1:0]      imem_rdata,
  output logic [INS_WIDTH-1:0]      instruction,
  output logic                      dp_rstn,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               instr_count
);

  localparam int DW = $clog2(PIPE_DEPTH + 1);
  localparam logic [INS_ADDR_WIDTH-1:0] PC_MAX = '1;

  fetch_state_t              state;
  logic [INS_ADDR_WIDTH-1:0] pc;
  logic                      phase;
  logic [DW-1:0]             drain_cnt;
  logic [OPCODE_WIDTH-1:0]   opcode;

  assign opcode    = imem_rdata[INS_WIDTH-1 -: OPCODE_WIDTH];
  assign imem_addr = pc;
  assign dp_rstn   = (state == ST_RUN) || (state == ST_DRAIN);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      pc          <= '0;
      phase       <= 1'b0;
      drain_cnt   <= '0;
      instruction <= '0;
      instr_count <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          phase <= 1'b0;
          if (start && !abort) begin
            state       <= ST_RUN;
            pc          <= '0;
            instr_count <= '0;
            busy        <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state       <= ST_IDLE;
            phase       <= 1'b0;
            instruction <= '0;
            busy        <= 1'b0;
          end else begin
            phase <= ~phase;
            // Capture only on phase=1 so the word is stable across the datapath half_clk edge.
            if (phase) begin
              if (opcode == OPC_HALT) begin
                instruction <= '0;
                drain_cnt   <= DW'(PIPE_DEPTH);
                state       <= ST_DRAIN;
              end else begin
                instruction <= imem_rdata;
                if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
                if (pc == PC_MAX) begin
                  drain_cnt <= DW'(PIPE_DEPTH);
                  state     <= ST_DRAIN;
                end else begin
                  pc <= pc + 1'b1;
                end
              end
            end
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state       <= ST_IDLE;
            phase       <= 1'b0;
            drain_cnt   <= '0;
            instruction <= '0;
            busy        <= 1'b0;
          end else begin
            phase <= ~phase;
            if (phase) begin
              instruction <= '0;
              drain_cnt   <= drain_cnt - 1'b1;
              if (drain_cnt == DW'(1)) begin
                state <= ST_DONE;
                phase <= 1'b0;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          phase       <= 1'b0;
          instruction <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a synchronous-ROM instruction memory model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int IAW = 8;
  localparam int AW  = 10;
  localparam int IW  = OPCODE_WIDTH + 3 * AW;

  logic           clk;
  logic           rstn;
  logic           start;
  logic           abort;
  logic [IAW-1:0] imem_addr;
  logic [IW-1:0]  imem_rdata;
  logic [IW-1:0]  instruction;
  logic           dp_rstn;
  logic           busy;
  logic           done;
  logic [15:0]    instr_count;

  logic [IW-1:0]  rom [256];
  logic [IW-1:0]  i0, i1, halt_w;

  int total = 0;
  int bad   = 0;
  int done_pulses = 0;

  fetch_unit #(
    .INS_ADDR_WIDTH(IAW), .ADDR_WIDTH(AW), .INS_WIDTH(IW), .PIPE_DEPTH(3)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instruction(instruction),
    .dp_rstn(dp_rstn), .busy(busy), .done(done), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= rom[imem_addr];
  always @(negedge clk) if (done === 1'b1) done_pulses++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_plain();
    for (int i = 0; i < 256; i++) rom[i] = {4'h3, 30'(i + 5)};
  endtask

  task automatic load_basic();
    fill_plain();
    rom[0] = i0;
    rom[1] = i1;
    rom[2] = halt_w;
  endtask

  // Leaves the bench just after edge 0, where start is sampled.
  task automatic kick();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; abort = 1'b0;
    tick(2);
    total++; if (instruction !== '0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instruction); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (dp_rstn !== 1'b0) begin bad++; $display("FAIL reset_dp_rstn got=%b exp=0", dp_rstn); end
    total++; if (instr_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
    total++; if (imem_addr !== 8'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", imem_addr); end
    rstn = 1'b1;
    tick(1);
  endtask

  task automatic test_basic();
    int d0;
    load_basic();
    d0 = done_pulses;
    kick();                                   // edge 0
    total++; if (busy !== 1'b1 || dp_rstn !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b/%b exp=1/1", busy, dp_rstn); end
    tick(1);                                  // edge 1
    total++; if (instruction !== '0) begin bad++; $display("FAIL basic_e1 got=%h exp=0", instruction); end
    tick(1);                                  // edge 2
    total++; if (instruction !== i0) begin bad++; $display("FAIL basic_i0 got=%h exp=%h", instruction, i0); end
    total++; if (imem_addr !== 8'd1) begin bad++; $display("FAIL basic_pc1 got=%0d exp=1", imem_addr); end
    tick(1);                                  // edge 3: held across the phase-0 edge
    total++; if (instruction !== i0) begin bad++; $display("FAIL basic_hold got=%h exp=%h", instruction, i0); end
    tick(1);                                  // edge 4
    total++; if (instruction !== i1) begin bad++; $display("FAIL basic_i1 got=%h exp=%h", instruction, i1); end
    tick(2);                                  // edge 6
    total++; if (instruction !== '0) begin bad++; $display("FAIL basic_nop got=%h exp=0", instruction); end
    total++; if (imem_addr !== 8'd2) begin bad++; $display("FAIL basic_pc_hold got=%0d exp=2", imem_addr); end
    tick(5);                                  // edge 11
    total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_e11 got=done%b busy%b exp=done0 busy1", done, busy); end
    tick(1);                                  // edge 12
    total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", done); end
    total++; if (dp_rstn !== 1'b0) begin bad++; $display("FAIL basic_done_dp got=%b exp=0", dp_rstn); end
    total++; if (instr_count !== 16'd2) begin bad++; $display("FAIL basic_count got=%0d exp=2", instr_count); end
    tick(1);                                  // edge 13
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=done%b busy%b exp=0/0", done, busy); end
    total++; if (done_pulses - d0 !== 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=1", done_pulses - d0); end
  endtask

  task automatic test_halt_first();
    fill_plain();
    rom[0] = halt_w;
    kick();                                   // edge 0
    tick(2);                                  // edge 2: HALT seen
    total++; if (instruction !== '0 || busy !== 1'b1) begin bad++; $display("FAIL halt0_drain got=%h/%b exp=0/1", instruction, busy); end
    tick(5);                                  // edge 7
    total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL halt0_e7 got=done%b busy%b exp=0/1", done, busy); end
    tick(1);                                  // edge 8: third drain slot
    total++; if (done !== 1'b1) begin bad++; $display("FAIL halt0_done got=%b exp=1", done); end
    total++; if (instr_count !== 16'd0) begin bad++; $display("FAIL halt0_count got=%0d exp=0", instr_count); end
    total++; if (instruction !== '0) begin bad++; $display("FAIL halt0_instr got=%h exp=0", instruction); end
    tick(1);
  endtask

  task automatic test_full_rom();
    logic [IW-1:0] last;
    fill_plain();
    last = rom[255];
    kick();                                   // edge 0
    tick(2);                                  // edge 2
    total++; if (instruction !== {4'h3, 30'd5}) begin bad++; $display("FAIL full_first got=%h exp=%h", instruction, {4'h3, 30'd5}); end
    tick(510);                                // edge 512: address 255 issues
    total++; if (instruction !== last) begin bad++; $display("FAIL full_last got=%h exp=%h", instruction, last); end
    total++; if (imem_addr !== 8'd255) begin bad++; $display("FAIL full_pc got=%0d exp=255", imem_addr); end
    tick(2);                                  // edge 514
    total++; if (imem_addr !== 8'd255 || instruction !== '0) begin bad++; $display("FAIL full_nowrap got=%0d/%h exp=255/0", imem_addr, instruction); end
    tick(4);                                  // edge 518
    total++; if (done !== 1'b1) begin bad++; $display("FAIL full_done got=%b exp=1", done); end
    total++; if (instr_count !== 16'd256) begin bad++; $display("FAIL full_count got=%0d exp=256", instr_count); end
    tick(1);
  endtask

  task automatic test_abort();
    int d0;
    load_basic();
    d0 = done_pulses;
    kick();                                   // edge 0
    tick(4);                                  // edge 4: I0 and I1 already issued
    abort = 1'b1;
    tick(1);                                  // edge 5
    abort = 1'b0;
    total++; if (busy !== 1'b0 || dp_rstn !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b/%b exp=0/0", busy, dp_rstn); end
    total++; if (instruction !== '0) begin bad++; $display("FAIL abort_instr got=%h exp=0", instruction); end
    total++; if (instr_count !== 16'd2) begin bad++; $display("FAIL abort_count got=%0d exp=2", instr_count); end
    tick(12);
    total++; if (done_pulses - d0 !== 0 || busy !== 1'b0) begin bad++; $display("FAIL abort_nodone got=%0d/%b exp=0/0", done_pulses - d0, busy); end
  endtask

  task automatic test_start_ignored();
    load_basic();
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0 || dp_rstn !== 1'b0) begin bad++; $display("FAIL start_abort got=%b/%b exp=0/0", busy, dp_rstn); end
    tick(1);
    kick();                                   // edge 0
    tick(2);                                  // edge 2
    start = 1'b1;
    tick(1);                                  // edge 3: restart must be ignored
    start = 1'b0;
    total++; if (imem_addr !== 8'd1 || instruction !== i0) begin bad++; $display("FAIL start_run_e3 got=%0d/%h exp=1/%h", imem_addr, instruction, i0); end
    tick(1);                                  // edge 4
    total++; if (instruction !== i1) begin bad++; $display("FAIL start_run_i1 got=%h exp=%h", instruction, i1); end
    tick(8);                                  // edge 12
    total++; if (done !== 1'b1 || instr_count !== 16'd2) begin bad++; $display("FAIL start_run_done got=%b/%0d exp=1/2", done, instr_count); end
    tick(1);
  endtask

  task automatic test_reset_in_drain();
    int d0;
    load_basic();
    d0 = done_pulses;
    kick();                                   // edge 0
    tick(7);                                  // edge 7: in DRAIN
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_drain_pre got=%b exp=1", busy); end
    rstn = 1'b0;
    tick(1);                                  // edge 8
    rstn = 1'b1;
    total++; if (busy !== 1'b0 || dp_rstn !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_drain_ctl got=%b%b%b exp=000", busy, dp_rstn, done); end
    total++; if (instruction !== '0 || instr_count !== 16'd0 || imem_addr !== 8'd0) begin bad++; $display("FAIL rst_drain_data got=%h/%0d/%0d exp=0/0/0", instruction, instr_count, imem_addr); end
    tick(10);
    total++; if (done_pulses - d0 !== 0) begin bad++; $display("FAIL rst_drain_nodone got=%0d exp=0", done_pulses - d0); end
  endtask

  initial begin
    i0     = {4'h1, 10'd11, 10'd22, 10'd33};
    i1     = {4'h2, 10'd44, 10'd55, 10'd66};
    halt_w = {OPC_HALT, 30'd0};
    fill_plain();
    test_reset();
    test_basic();
    test_halt_first();
    test_full_rom();
    test_abort();
    test_start_ignored();
    test_reset_in_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
